// File: rtl/led_event_blinker_pkg.sv
// Shared button/LED utility constants: state encoding and time-to-cycles conversion.
package led_event_blinker_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_ON   = ON,
        ST_OFF  = OFF
    } state_t;

    // Whole clock cycles in a duration, rounded down.
    function automatic int unsigned cycles_from_seconds(input real freq_hz, input real secs);
        return 32'($rtoi($floor(freq_hz * secs)));
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_event_blinker_if.sv
// Event-in / LED-out bundle between control logic (master) and the blinker (slave).
interface led_event_blinker_if #(
    parameter int unsigned PEND_W = 3
);
    logic              event_i;
    logic              ovf_clr;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output event_i, ovf_clr,
        input  led, busy, pending, overflow
    );

    modport slave (
        input  event_i, ovf_clr,
        output led, busy, pending, overflow
    );
endinterface

// File: rtl/led_event_blinker_sat_counter.sv
// Saturating up/down counter; simultaneous inc and dec leave the count unchanged.
module sat_counter #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max_c
);

    assign at_max_c = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !at_max_c) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into visible LED blinks, queueing events that arrive mid-blink.
module led_event_blinker
    import led_event_blinker_pkg::*;
#(
    parameter int unsigned SYSCLK_FREQ = 12000000,
    parameter real         ON_TIME     = 0.050,
    parameter real         OFF_TIME    = 0.050,
    parameter int unsigned MAX_PENDING = 7,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input logic               clk,
    input logic               rst,
    led_event_blinker_if.slave bus
);

    localparam int unsigned ON_CYCLES  = cycles_from_seconds(real'(SYSCLK_FREQ), ON_TIME);
    localparam int unsigned OFF_CYCLES = cycles_from_seconds(real'(SYSCLK_FREQ), OFF_TIME);
    localparam int unsigned TMR_W      = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);
    localparam int unsigned PEND_W     = $clog2(MAX_PENDING + 1);

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               led_q;
    logic               busy_q;
    logic               overflow_q;
    logic [PEND_W-1:0]  pend_cnt;
    logic               pend_at_max_c;

    logic on_last_c;
    logic off_last_c;
    logic pend_nz_c;
    logic enq_c;
    logic deq_c;
    logic drop_c;

    assign on_last_c  = (state == ST_ON)  && (timer == TMR_W'(ON_CYCLES - 1));
    assign off_last_c = (state == ST_OFF) && (timer == TMR_W'(OFF_CYCLES - 1));
    assign pend_nz_c  = (pend_cnt != '0);

    // An event on the last OFF cycle with an empty queue starts the next blink itself.
    assign enq_c  = bus.event_i &&
                    ((state == ST_ON) || ((state == ST_OFF) && !(off_last_c && !pend_nz_c)));
    assign deq_c  = off_last_c && pend_nz_c;
    assign drop_c = enq_c && pend_at_max_c && !deq_c;

    sat_counter #(
        .W   (PEND_W),
        .MAX (MAX_PENDING)
    ) u_pending (
        .clk      (clk),
        .rst      (rst),
        .inc      (enq_c),
        .dec      (deq_c),
        .count    (pend_cnt),
        .at_max_c (pend_at_max_c)
    );

    // Blink sequencer; led/busy are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            timer  <= '0;
            led_q  <= ACTIVE_LOW;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.event_i) begin
                        state  <= ST_ON;
                        timer  <= '0;
                        led_q  <= ~ACTIVE_LOW;
                        busy_q <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (on_last_c) begin
                        state <= ST_OFF;
                        timer <= '0;
                        led_q <= ACTIVE_LOW;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_OFF: begin
                    if (off_last_c) begin
                        timer <= '0;
                        if (pend_nz_c || bus.event_i) begin
                            state <= ST_ON;
                            led_q <= ~ACTIVE_LOW;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    timer  <= '0;
                    led_q  <= ACTIVE_LOW;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop_c) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend_cnt;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed bench: 4-cycle ON, 3-cycle OFF, queue depth 3, plus an active-low instance.
module tb_led_event_blinker;

    localparam int unsigned PW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ev  = 1'b0;
    logic clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_event_blinker_if #(.PEND_W(PW)) bus0 ();
    led_event_blinker_if #(.PEND_W(PW)) bus1 ();

    assign bus0.event_i = ev;
    assign bus0.ovf_clr = clr;
    assign bus1.event_i = ev;
    assign bus1.ovf_clr = clr;

    led_event_blinker #(
        .SYSCLK_FREQ (1000),
        .ON_TIME     (0.004),
        .OFF_TIME    (0.003),
        .MAX_PENDING (3),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    led_event_blinker #(
        .SYSCLK_FREQ (1000),
        .ON_TIME     (0.004),
        .OFF_TIME    (0.003),
        .MAX_PENDING (3),
        .ACTIVE_LOW  (1'b1)
    ) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ev = 1'b1; clr = 1'b0;
        tick();
        tick();
        rst = 1'b0; ev = 1'b0;
        n_cmp++; if (bus0.led !== 1'b0) begin n_bad++; $display("FAIL reset_led got %b want 0", bus0.led); end
        n_cmp++; if (bus1.led !== 1'b1) begin n_bad++; $display("FAIL reset_led_al got %b want 1", bus1.led); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
        n_cmp++; if (bus0.pending !== 2'd0) begin n_bad++; $display("FAIL reset_pending got %0d want 0", bus0.pending); end
        n_cmp++; if (bus0.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", bus0.overflow); end
    endtask

    task automatic test_single();
        logic el, eb;
        for (int c = 0; c < 10; c++) begin
            ev = (c == 0);
            tick();
            el = (c + 1 >= 1) && (c + 1 <= 4);
            eb = (c + 1 >= 1) && (c + 1 <= 7);
            n_cmp++; if (bus0.led !== el) begin n_bad++; $display("FAIL single_led r%0d got %b want %b", c + 1, bus0.led, el); end
            n_cmp++; if (bus0.busy !== eb) begin n_bad++; $display("FAIL single_busy r%0d got %b want %b", c + 1, bus0.busy, eb); end
            n_cmp++; if (bus0.pending !== 2'd0) begin n_bad++; $display("FAIL single_pending r%0d got %0d want 0", c + 1, bus0.pending); end
        end
        ev = 1'b0;
    endtask

    task automatic test_queue();
        logic el, eb;
        logic [1:0] ep;
        int r;
        for (int c = 0; c < 23; c++) begin
            ev = (c == 0) || (c == 2) || (c == 3);
            tick();
            r  = c + 1;
            el = (r >= 1 && r <= 4) || (r >= 8 && r <= 11) || (r >= 15 && r <= 18);
            eb = (r >= 1 && r <= 21);
            ep = (r == 3) ? 2'd1 : (r >= 4 && r <= 7) ? 2'd2 : (r >= 8 && r <= 14) ? 2'd1 : 2'd0;
            n_cmp++; if (bus0.led !== el) begin n_bad++; $display("FAIL queue_led r%0d got %b want %b", r, bus0.led, el); end
            n_cmp++; if (bus0.busy !== eb) begin n_bad++; $display("FAIL queue_busy r%0d got %b want %b", r, bus0.busy, eb); end
            n_cmp++; if (bus0.pending !== ep) begin n_bad++; $display("FAIL queue_pending r%0d got %0d want %0d", r, bus0.pending, ep); end
        end
        ev = 1'b0;
    endtask

    task automatic test_overflow();
        logic el, eb, eo;
        logic [1:0] ep;
        int r;
        for (int c = 0; c < 30; c++) begin
            ev  = (c <= 5);
            clr = (c == 5) || (c == 6);
            tick();
            r  = c + 1;
            el = (r >= 1 && r <= 4) || (r >= 8 && r <= 11) || (r >= 15 && r <= 18) || (r >= 22 && r <= 25);
            eb = (r >= 1 && r <= 28);
            eo = (r == 5) || (r == 6);
            ep = (r == 2) ? 2'd1 : (r == 3) ? 2'd2 : (r >= 4 && r <= 7) ? 2'd3 :
                 (r >= 8 && r <= 14) ? 2'd2 : (r >= 15 && r <= 21) ? 2'd1 : 2'd0;
            n_cmp++; if (bus0.led !== el) begin n_bad++; $display("FAIL ovf_led r%0d got %b want %b", r, bus0.led, el); end
            n_cmp++; if (bus0.busy !== eb) begin n_bad++; $display("FAIL ovf_busy r%0d got %b want %b", r, bus0.busy, eb); end
            n_cmp++; if (bus0.pending !== ep) begin n_bad++; $display("FAIL ovf_pending r%0d got %0d want %0d", r, bus0.pending, ep); end
            n_cmp++; if (bus0.overflow !== eo) begin n_bad++; $display("FAIL ovf_flag r%0d got %b want %b", r, bus0.overflow, eo); end
        end
        ev = 1'b0; clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic el, eb;
        int r;
        for (int c = 0; c < 16; c++) begin
            ev = (c == 0) || (c == 7);
            tick();
            r  = c + 1;
            el = (r >= 1 && r <= 4) || (r >= 8 && r <= 11);
            eb = (r >= 1 && r <= 14);
            n_cmp++; if (bus0.led !== el) begin n_bad++; $display("FAIL b2b_led r%0d got %b want %b", r, bus0.led, el); end
            n_cmp++; if (bus0.busy !== eb) begin n_bad++; $display("FAIL b2b_busy r%0d got %b want %b", r, bus0.busy, eb); end
            n_cmp++; if (bus0.pending !== 2'd0) begin n_bad++; $display("FAIL b2b_pending r%0d got %0d want 0", r, bus0.pending); end
        end
        ev = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic el, eb;
        for (int c = 0; c < 3; c++) begin
            ev = 1'b1;
            tick();
        end
        ev = 1'b0;
        n_cmp++; if (bus0.pending !== 2'd2) begin n_bad++; $display("FAIL rstmid_pre_pending got %0d want 2", bus0.pending); end
        n_cmp++; if (bus0.led !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_led got %b want 1", bus0.led); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus0.led !== 1'b0) begin n_bad++; $display("FAIL rstmid_led got %b want 0", bus0.led); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus0.busy); end
        n_cmp++; if (bus0.pending !== 2'd0) begin n_bad++; $display("FAIL rstmid_pending got %0d want 0", bus0.pending); end
        n_cmp++; if (bus0.overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow got %b want 0", bus0.overflow); end
        for (int c = 0; c < 9; c++) begin
            ev = (c == 0);
            tick();
            el = (c + 1 <= 4);
            eb = (c + 1 <= 7);
            n_cmp++; if (bus0.led !== el) begin n_bad++; $display("FAIL rstmid_blink_led s%0d got %b want %b", c + 1, bus0.led, el); end
            n_cmp++; if (bus0.busy !== eb) begin n_bad++; $display("FAIL rstmid_blink_busy s%0d got %b want %b", c + 1, bus0.busy, eb); end
        end
        ev = 1'b0;
    endtask

    task automatic test_active_low();
        logic el, eb;
        for (int c = 0; c < 10; c++) begin
            ev = (c == 0);
            tick();
            el = !((c + 1 >= 1) && (c + 1 <= 4));
            eb = (c + 1 <= 7);
            n_cmp++; if (bus1.led !== el) begin n_bad++; $display("FAIL al_led r%0d got %b want %b", c + 1, bus1.led, el); end
            n_cmp++; if (bus1.busy !== eb) begin n_bad++; $display("FAIL al_busy r%0d got %b want %b", c + 1, bus1.busy, eb); end
            n_cmp++; if (bus1.pending !== 2'd0) begin n_bad++; $display("FAIL al_pending r%0d got %0d want 0", c + 1, bus1.pending); end
        end
        ev = 1'b0;
    endtask

    initial begin
        test_reset();
        tick();
        test_single();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_active_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_event_blinker.md
Name: led_event_blinker

Overview:
- Output-side counterpart to the button input conditioner: turns single-cycle event pulses into human-visible LED blinks.
- Each accepted event produces exactly one blink: LED on for ON_TIME, then off for at least OFF_TIME.
- Events that arrive during a blink are queued in a saturating pending counter. Overflow is reported on a sticky flag.
- Sits between control logic (debounced presses, status strobes) and a board LED pin.

Parameters:
- SYSCLK_FREQ, 12000000, system clock frequency in Hz.
- ON_TIME, 0.050, LED on duration in seconds. ON_CYCLES = $rtoi($floor(SYSCLK_FREQ*ON_TIME)); must be >= 1.
- OFF_TIME, 0.050, minimum LED off gap between blinks in seconds. OFF_CYCLES computed the same way; must be >= 1.
- MAX_PENDING, 7, maximum number of queued blinks; must be >= 1.
- ACTIVE_LOW, 0, 1 inverts the led output pin polarity only.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- event_i  input  1  single-cycle event strobe; each high cycle counts as one event.
- ovf_clr  input  1  clears the sticky overflow flag.
- led  output  1  LED drive; logical on = 1 when ACTIVE_LOW=0.
- busy  output  1  high whenever state != IDLE.
- pending  output  $clog2(MAX_PENDING+1)  number of queued blinks not yet started.
- overflow  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset state (synchronous, active-high): state=IDLE, timer=0, pending=0, overflow=0, busy=0, led logical off (pin=ACTIVE_LOW). All outputs are registered.
- States:
  - IDLE: led off.
  - ON: led on.
  - OFF: led off.
- IDLE transitions:
  - event_i=1 → ON, timer=0. pending is not incremented.
  - led is on from the cycle after the sampling edge (latency 1).
- ON:
  - Lasts exactly ON_CYCLES cycles, then → OFF with timer=0.
- OFF:
  - Lasts exactly OFF_CYCLES cycles.
  - On the last OFF cycle: if pending>0 or event_i=1 → ON; otherwise → IDLE.
- Pending queue rules:
  - Enqueue: event_i=1 while in ON or OFF.
  - Dequeue: leaving OFF for ON because pending>0.
  - Enqueue and dequeue in the same cycle: pending unchanged.
  - event_i=1 on the last OFF cycle with pending=0: the event starts the next blink directly; pending stays 0.
  - Enqueue with pending==MAX_PENDING and no dequeue that cycle: event dropped, overflow<=1, pending holds.
- overflow:
  - Set only by a dropped event.
  - Cleared by ovf_clr=1.
  - Set and clear in the same cycle: set wins.
- Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1). The timer compares against the count minus 1 and never wraps.
- Blink periods are back-to-back with no extra IDLE cycle: period = ON_CYCLES+OFF_CYCLES.
- busy stays high through the final OFF gap. Consumers may rely on busy=0 meaning at least OFF_CYCLES have elapsed since the led went off.
- Reset mid-blink: led is off the cycle after rst is sampled; the queue and overflow are discarded.
- event_i held high for N cycles counts as N events; it is not edge-detected.

Decomposition:
- Shared package (button/LED utility constants): cycles_from_seconds helper and the state encoding localparams (IDLE, ON, OFF).
- One natural sub-module: sat_counter (saturating up/down counter with inc, dec and at-max outputs), used for pending.
- FSM and timer stay in the top-level module.

Test Plan:
Bench config: SYSCLK_FREQ=1000, ON_TIME=0.004 (4 cycles), OFF_TIME=0.003 (3 cycles), MAX_PENDING=3.
1. Single event at cycle 10 → led=1 in cycles 11-14, led=0 from cycle 15; busy=1 in cycles 11-17, busy=0 at cycle 18; pending stays 0.
2. Events at cycles 10, 12, 13 → three blinks starting at cycles 11, 18, 25; pending reads 1, then 2, then decrements at each blink start; busy falls at cycle 32.
3. Five events during the first ON → pending saturates at 3, overflow=1 after the fifth; four blinks total. An ovf_clr pulse coincident with a further drop leaves overflow=1.
4. Event exactly on the last OFF cycle with pending=0 → next blink starts with no IDLE gap; pending remains 0.
5. rst asserted in the middle of ON with pending=2 → next cycle led=0, busy=0, pending=0, overflow=0. A subsequent event gives a normal 4-cycle blink.
6. ACTIVE_LOW=1 rerun of scenario 1 → led pin inverted (idle 1, on 0); all timing identical.
